hazard_scoreboard: RTL

- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Tracks destination registers of in-flight instructions in a 3-entry scoreboard shift register covering EX, MEM and WB.
- Produces IF/ID stall, pipeline flush and per-operand EX forwarding selects.
- Generalises to NSRC source operands and keeps saturating stall/flush performance counters.

---
 rtl/hazard_scoreboard.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard detection and EX forwarding control for a 5-stage
// pipeline. A 3-entry scoreboard shift register (EX, MEM, WB) holds the
// destination registers of in-flight instructions.
// Build option: define HAZARD_FWD_EN to enable operand forwarding. Without it,
// any dependency on an in-flight producer stalls until the producer has left
// WB, and fwd_sel stays 0.
module hazard_scoreboard #(
  parameter int unsigned RA_W  = 4,
  parameter int unsigned NSRC  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*RA_W-1:0]   id_rs,
  input  logic [NSRC-1:0]        id_use,
  input  logic [RA_W-1:0]        id_rd,
  input  logic                   id_wr_en,
  input  logic                   id_is_load,
  input  logic                   ex_branch_taken,
  output logic                   stall,
  output logic                   flush,
  output logic [2*NSRC-1:0]      fwd_sel,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam int unsigned DEPTH = 3;

  // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB. Only the EX entry's load flag
  // matters (a load is only a hazard while it sits in EX), so older stages
  // keep just valid and rd.
  logic [DEPTH-1:0] e_v;
  logic [RA_W-1:0]  e_rd [DEPTH];
  logic             e0_ld;

  // match[j][k]: operand k of the ID instruction depends on entry j
  logic [NSRC-1:0]  match [DEPTH];
  logic             hazard;
  logic             issue;
  logic [2*NSRC-1:0] fwd_sel_d;

  // Compare every used source operand against every valid scoreboard entry
  always_comb begin
    for (int j = 0; j < int'(DEPTH); j++) begin
      match[j] = '0;
      for (int k = 0; k < int'(NSRC); k++) begin
        match[j][k] = id_use[k] & id_valid & e_v[j] &
                      (e_rd[j] == id_rs[k*RA_W +: RA_W]);
      end
    end
  end

  // Hazard source: load-use only with forwarding, any dependency without
  always_comb begin
    hazard = 1'b0;
`ifdef HAZARD_FWD_EN
    hazard = e0_ld & (|match[0]);
`else
    for (int j = 0; j < int'(DEPTH); j++) begin
      hazard = hazard | (|match[j]);
    end
`endif
  end

  // Flush wins over stall; a flushed or stalled instruction is not recorded
  always_comb begin
    flush = ex_branch_taken;
    stall = hazard & ~ex_branch_taken;
    issue = id_valid & id_wr_en & ~stall & ~flush;
  end

  // Per-operand forwarding select, youngest producer first; bubble on stall/flush
  always_comb begin
    fwd_sel_d = '0;
`ifdef HAZARD_FWD_EN
    if (!stall && !flush) begin
      for (int k = 0; k < int'(NSRC); k++) begin
        if (match[0][k])      fwd_sel_d[2*k +: 2] = 2'd1;
        else if (match[1][k]) fwd_sel_d[2*k +: 2] = 2'd2;
        else if (match[2][k]) fwd_sel_d[2*k +: 2] = 2'd3;
        else                  fwd_sel_d[2*k +: 2] = 2'd0;
      end
    end
`endif
  end

  // Scoreboard shift: every edge, new entry enters EX (bubble when not issued)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_v   <= '0;
      e0_ld <= 1'b0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        e_rd[j] <= '0;
      end
    end else begin
      e_v   <= {e_v[DEPTH-2:0], issue};
      e0_ld <= issue & id_is_load;
      e_rd[2] <= e_rd[1];
      e_rd[1] <= e_rd[0];
      e_rd[0] <= issue ? id_rd : '0;
    end
  end

  // Forwarding select register, valid while the instruction is in EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_sel <= '0;
    end else begin
      fwd_sel <= fwd_sel_d;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
